// File: rtl/instruction_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: reset fetch address,
// fetch stride and the buffered {pc, instruction} entry layout.
package instruction_prefetch_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] FETCH_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_if.sv
// Bundle of the prefetch unit's memory bus, pipeline handshake and redirect
// signals; master is the prefetch side, slave is the memory/pipeline side.
interface instruction_prefetch_if #(
    parameter int DEPTH = 4
);
    localparam int OccW = $clog2(DEPTH + 1);

    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instruction;
    logic [31:0]     out_pc;
    logic [OccW-1:0] occupancy;

    modport master (
        input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instruction, out_pc, occupancy
    );

    modport slave (
        output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instruction, out_pc, occupancy
    );

endinterface

// File: rtl/instruction_prefetch_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instruction} entries with a flush
// that empties it in one cycle; pointers wrap by natural overflow.
module fetch_queue
    import instruction_prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PtrW  = $clog2(DEPTH),
    localparam int CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  fetch_entry_t    data_i,
    output fetch_entry_t    data_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assert property (@(posedge clock) disable iff (!reset_n)
        !(push_i && !pop_i && !flush_i && count_q == CntW'(DEPTH)));

    assert property (@(posedge clock) disable iff (!reset_n)
        !(pop_i && !flush_i && count_q == '0));

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch unit: credit-limited in-order fetches into a small
// queue feeding IF/ID; redirects flush the queue and drop stale responses.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = TEXT_BASE
) (
    input  logic                   clock,
    input  logic                   reset_n,
    instruction_prefetch_if.master bus
);

    localparam int CntW = $clog2(DEPTH + 1);
    // Back-to-back redirects can leave more than DEPTH responses in flight.
    localparam int CredW = CntW + 3;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CredW-1:0] outstanding_q, outstanding_d;
    logic [CredW-1:0] discard_q, discard_d;
    logic             started_q;

    logic [CntW-1:0]  count;
    logic [CredW-1:0] inUse;
    logic             grant;
    logic             drop;
    logic             push;
    logic             pop;
    fetch_entry_t     pushEntry;
    fetch_entry_t     head;

    assign inUse        = CredW'(count) + outstanding_q - discard_q;
    assign bus.mem_req  = started_q & ~bus.redirect & (inUse < CredW'(DEPTH));
    assign bus.mem_addr = fetch_pc_q;
    assign grant        = bus.mem_req & bus.mem_gnt;

    assign drop = bus.mem_rvalid & (discard_q != '0);
    assign push = bus.mem_rvalid & ~drop & ~bus.redirect;

    assign bus.out_valid       = (count != '0) & ~bus.redirect;
    assign pop                 = bus.out_valid & bus.out_ready;
    assign bus.out_instruction = head.instr;
    assign bus.out_pc          = head.pc;
    assign bus.occupancy       = count;

    assign pushEntry = '{pc: resp_pc_q, instr: bus.mem_rdata};

    // Redirect overrides everything: every response still owed becomes a
    // discard, including one that happens to arrive this very cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CredW'(grant) - CredW'(bus.mem_rvalid);
        discard_d     = discard_q - CredW'(drop);
        if (grant) fetch_pc_d = fetch_pc_q + FETCH_STEP;
        if (push)  resp_pc_d  = resp_pc_q + FETCH_STEP;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            discard_d  = outstanding_q - CredW'(bus.mem_rvalid);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            started_q     <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect),
        .data_i  (pushEntry),
        .data_o  (head),
        .count_o (count)
    );

    assert property (@(posedge clock) disable iff (!reset_n)
        !(bus.mem_rvalid && outstanding_q == '0));

endmodule
